// File: rtl/simon_seq_pkg.sv
// rtl/simon_seq_pkg.sv - shared types and codes for the Simon round sequencer
//
// Contents:
//   state_t     game FSM states (INPUT, PLAYBACK, REPEAT, DONE)
//   SEL_*       datapath read/display source codes driven on select
//   MODE_*      mode LED patterns driven on mode_leds
//   mode_of()   maps a state to its LED pattern
package simon_seq_pkg;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] SEL_INPUT  = 2'd0;
  localparam logic [1:0] SEL_PLAY   = 2'd1;
  localparam logic [1:0] SEL_REPEAT = 2'd2;
  localparam logic [1:0] SEL_DONE   = 2'd3;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;

  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      ST_INPUT:    mode_of = MODE_INPUT;
      ST_PLAYBACK: mode_of = MODE_PLAYBACK;
      ST_REPEAT:   mode_of = MODE_REPEAT;
      default:     mode_of = MODE_DONE;
    endcase
  endfunction

endpackage

// File: rtl/simon_hold_timer.sv
// rtl/simon_hold_timer.sv - wrap counter with clear, enable and terminal pulse
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset, count -> 0
//   clr       in   synchronous clear to 0 (wins over en)
//   en        in   count this cycle
//   terminal  out  en and count at LIMIT-1; counter wraps to 0 on the next edge
module simon_hold_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int unsigned W = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // LIMIT=1 keeps count at 0, so terminal fires on every enabled cycle.
  assign terminal = en & (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game round FSM driving the datapath controls
//
// Optional feature macro: SIMON_SEQ_TIMEOUT_EN (REPEAT-mode inactivity timeout).
//
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   guess             in   one-cycle user-submit strobe
//   is_legal          in   user pattern is legal
//   play_gt_count     in   play index has passed last stored entry
//   repeat_eq_play    in   repeat index equals last stored entry
//   input_eq_pattern  in   user pattern matches entry at repeat index
//   select[1:0]       out  datapath read/display source (registered state decode)
//   mode_leds[2:0]    out  mode indicator (registered state decode)
//   w_en              out  store user pattern, count+1 (combinational pulse)
//   clrcount          out  clear play/repeat indices (combinational pulse)
//   step              out  advance active index (combinational pulse)
module simon_sequencer
  import simon_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       guess,
  input  logic       is_legal,
  input  logic       play_gt_count,
  input  logic       repeat_eq_play,
  input  logic       input_eq_pattern,
  output logic [1:0] select,
  output logic [2:0] mode_leds,
  output logic       w_en,
  output logic       clrcount,
  output logic       step
);

  state_t state, state_next;
  logic   w_en_c, clrcount_c, step_c;
  logic   showing;
  logic   hold_clr, hold_term;
  logic   timeout;

  // PLAYBACK and DONE both pace the stored sequence at the hold rate.
  assign showing = (state == ST_PLAYBACK) || (state == ST_DONE);

  // Held at 0 outside the display modes so every entry starts a full hold;
  // also restarted on the end-of-sequence cycle so a DONE wrap does too.
  assign hold_clr = !showing || play_gt_count;

  simon_hold_timer #(.LIMIT(HOLD_CYCLES)) u_hold (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (hold_clr),
    .en       (showing),
    .terminal (hold_term)
  );

`ifdef SIMON_SEQ_TIMEOUT_EN
  logic to_term;

  simon_hold_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst),
    .clr      ((state != ST_REPEAT) || guess),
    .en       (state == ST_REPEAT),
    .terminal (to_term)
  );

  // A guess landing on the terminal cycle is processed as a guess instead.
  assign timeout = to_term && !guess;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INPUT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    w_en_c     = 1'b0;
    clrcount_c = 1'b0;
    step_c     = 1'b0;
    case (state)
      ST_INPUT: begin
        if (guess && is_legal) begin
          w_en_c     = 1'b1;
          clrcount_c = 1'b1;
          state_next = ST_PLAYBACK;
        end
      end
      ST_PLAYBACK: begin
        if (play_gt_count) begin
          clrcount_c = 1'b1;
          state_next = ST_REPEAT;
        end else if (hold_term) begin
          step_c = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (guess) begin
          if (!input_eq_pattern) begin
            clrcount_c = 1'b1;
            state_next = ST_DONE;
          end else if (repeat_eq_play) begin
            clrcount_c = 1'b1;
            state_next = ST_INPUT;
          end else begin
            step_c = 1'b1;
          end
        end else if (timeout) begin
          clrcount_c = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: begin
        // DONE: endless replay, wrapping back to the first entry.
        if (play_gt_count) begin
          clrcount_c = 1'b1;
        end else if (hold_term) begin
          step_c = 1'b1;
        end
      end
    endcase
  end

  // Strobes are suppressed while reset is held, even though state is INPUT.
  assign w_en     = rst & w_en_c;
  assign clrcount = rst & clrcount_c;
  assign step     = rst & step_c;

  assign mode_leds = mode_of(state);

  always_comb begin
    select = SEL_INPUT;
    case (state)
      ST_INPUT:    select = SEL_INPUT;
      ST_PLAYBACK: select = SEL_PLAY;
      ST_REPEAT:   select = SEL_REPEAT;
      default:     select = SEL_DONE;
    endcase
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Round-sequencing controller for the Simon game datapath. Owns the game FSM (input, playback, repeat, done), drives the datapath's read-select, write-enable, index-clear and index-step controls, and reacts to the datapath's comparison flags. Paces playback at a fixed hold time per pattern and accepts one user guess per `guess` strobe. Sits between the debounced user-input logic and the datapath inside the Simon top level.

## Interface
- HOLD_CYCLES, 4: clock cycles each pattern is displayed during playback/done replay; ≥1.
- TIMEOUT_CYCLES, 1024: repeat-mode inactivity limit; used only with timeout enabled; ≥2.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- guess  input  1  one-cycle strobe: user pattern is submitted this cycle.
- is_legal  input  1  datapath: current user pattern is legal.
- play_gt_count  input  1  datapath: play index has passed last stored entry.
- repeat_eq_play  input  1  datapath: repeat index equals last stored entry.
- input_eq_pattern  input  1  datapath: user pattern matches stored entry at repeat index.
- select  output  2  datapath display/read source: SEL_INPUT=0, SEL_PLAY=1, SEL_REPEAT=2, SEL_DONE=3.
- mode_leds  output  3  INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111.
- w_en  output  1  write user pattern into sequence memory, count+1.
- clrcount  output  1  clear datapath play/repeat indices.
- step  output  1  advance active datapath index by one.

## Operation
- States: INPUT, PLAYBACK, REPEAT, DONE. select/mode_leds decoded from state register only. w_en, clrcount, step are combinational from state + inputs, one-cycle pulses.
- INPUT: guess & is_legal → w_en=1, clrcount=1, next PLAYBACK. guess & !is_legal → no strobes, stay.
- PLAYBACK: hold counter runs; at HOLD_CYCLES-1 → step=1, counter wraps to 0. play_gt_count=1 → clrcount=1, next REPEAT, no step (takes priority over hold terminal).
- REPEAT: guess & input_eq_pattern & !repeat_eq_play → step=1, stay. guess & input_eq_pattern & repeat_eq_play → clrcount=1, next INPUT. guess & !input_eq_pattern → clrcount=1, next DONE.
- DONE: replays whole sequence forever like PLAYBACK; play_gt_count=1 → clrcount=1 (wrap to first entry), stay. Exit only via rst.
- guess ignored in PLAYBACK and DONE. Hold counter cleared on every entry to PLAYBACK or DONE.
- Hold counter width $clog2(HOLD_CYCLES)+1; HOLD_CYCLES=1 → step every cycle.

## Timing
- Reset (rst=0, async): state INPUT, select=0, mode_leds=001, w_en=clrcount=step=0 (strobes forced low while rst=0), all counters 0. First transition possible on first rising edge after rst deasserts.
- Strobes valid same cycle as triggering input; state change at next edge. Guess-to-mode-change latency 1 cycle.
- Playback of N entries: N·HOLD_CYCLES cycles of step pacing, +1 cycle for play_gt_count exit.
- Reset mid-round: immediate return to INPUT; datapath memory not cleared by this block.

## Configuration
- SIMON_SEQ_TIMEOUT_EN defined: REPEAT counts cycles since entry or last guess; reaching TIMEOUT_CYCLES-1 with no guess → clrcount=1, next DONE. guess in terminal cycle wins (normal guess handling, counter reset).
- Undefined: no timeout counter synthesized, REPEAT waits indefinitely, TIMEOUT_CYCLES ignored.

## Structure
- Package simon_seq_pkg: state enum, SEL_* select codes, MODE_* LED codes.
- One sub-module simon_hold_timer: parameterized wrap counter with clear, enable, terminal pulse; instanced for hold pacing and (under macro) timeout.

## Test plan
- Reset then guess with is_legal=1 → w_en=clrcount=1 same cycle, mode_leds=010 next cycle; guess with is_legal=0 → no strobes, mode 001 held.
- PLAYBACK, HOLD_CYCLES=4 → step every 4th cycle; raise play_gt_count → clrcount=1, mode_leds=100 next cycle, no step.
- REPEAT: 2 correct guesses (repeat_eq_play=0 then 1) → step then clrcount, back to mode 001.
- REPEAT wrong guess (input_eq_pattern=0) → clrcount=1, mode_leds=111; DONE wraps on play_gt_count; guess ignored.
- Timeout build, TIMEOUT_CYCLES=8, no guess → DONE after 8 cycles; guess on cycle 8 → handled as guess, no timeout.
- Assert rst=0 mid-PLAYBACK → outputs reset values asynchronously, mode 001 after release.
